fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter_pkg.sv | 14 +
 rtl/fb_write_arbiter_rr_arb2.sv | 20 ++
 rtl/fb_write_arbiter.sv | 118 +++++++++++
 tb/tb_fb_write_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Frame buffer write arbiter: shared constants and state encoding.
// Sized for an 800x480 panel stored as 16-pixel words.
package fb_write_arbiter_pkg;

  localparam int FB_WORDS  = 24000;
  localparam int FB_ADDR_W = 16;
  localparam int FB_WORD_W = 16;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/fb_write_arbiter_rr_arb2.sv
// Two-way round-robin grant; last names the requester
// that won the previous handshake.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // On a tie, favour the requester that did not win last time.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame buffer write port shared by two requesters plus a
// full-screen fill engine; one word written per cycle.
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int WORDS  = FB_WORDS,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_req,
  input  logic [FB_WORD_W-1:0] clear_pattern,
  output logic                 clear_busy,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [FB_WORD_W-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [FB_WORD_W-1:0] req1_data,
  output logic                 req1_ready,
  output logic [ADDR_W-1:0]    fb_write_address,
  output logic [FB_WORD_W-1:0] fb_data_in,
  output logic                 fb_load,
  output logic                 oob_flag
);

  localparam logic [ADDR_W:0]   WORDS_X = (ADDR_W+1)'(WORDS);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(WORDS - 1);

  state_t                 state;
  logic                   last_grant;
  logic [ADDR_W-1:0]      fill_cnt;
  logic [FB_WORD_W-1:0]   pattern;
  logic [1:0]             arb_req;
  logic [1:0]             grant;
  logic                   hs;
  logic [ADDR_W-1:0]      sel_addr;
  logic [FB_WORD_W-1:0]   sel_data;
  logic                   sel_oob;

  // Requests only compete in ARB, and a fill request
  // pre-empts them on the cycle it arrives.
  always_comb begin
    arb_req = 2'b00;
    if (state == ARB && !clear_req)
      arb_req = {req1_valid, req0_valid};
  end

  rr_arb2 u_arb (
    .req   (arb_req),
    .last  (last_grant),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign hs         = |grant;
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;
  assign sel_oob    = {1'b0, sel_addr} >= WORDS_X;

  // Control FSM with registered write port and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ARB;
      last_grant       <= 1'b1;
      fill_cnt         <= '0;
      pattern          <= '0;
      fb_load          <= 1'b0;
      fb_write_address <= '0;
      fb_data_in       <= '0;
      clear_busy       <= 1'b0;
      oob_flag         <= 1'b0;
    end else begin
      unique case (state)
        ARB: begin
          if (clear_req) begin
            state            <= CLEAR;
            pattern          <= clear_pattern;
            fill_cnt         <= '0;
            fb_load          <= 1'b1;
            fb_write_address <= '0;
            fb_data_in       <= clear_pattern;
            clear_busy       <= 1'b1;
          end else if (hs) begin
            last_grant <= grant[1];
            if (sel_oob) begin
              oob_flag <= 1'b1;
              fb_load  <= 1'b0;
            end else begin
              fb_load          <= 1'b1;
              fb_write_address <= sel_addr;
              fb_data_in       <= sel_data;
            end
          end else begin
            fb_load <= 1'b0;
          end
        end
        CLEAR: begin
          if (fill_cnt == LAST) begin
            state      <= ARB;
            fill_cnt   <= '0;
            fb_load    <= 1'b0;
            clear_busy <= 1'b0;
          end else begin
            fill_cnt         <= fill_cnt + 1'b1;
            fb_write_address <= fill_cnt + 1'b1;
            fb_data_in       <= pattern;
            fb_load          <= 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed stimulus, write-port
// scoreboard checked by an independent monitor.
module tb_fb_write_arbiter;

  localparam int N = 24000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_req;
  logic [15:0] clear_pattern;
  logic        clear_busy;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [15:0] fb_write_address;
  logic [15:0] fb_data_in;
  logic        fb_load;
  logic        oob_flag;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fb_write_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .clear_req        (clear_req),
    .clear_pattern    (clear_pattern),
    .clear_busy       (clear_busy),
    .req0_valid       (req0_valid),
    .req0_addr        (req0_addr),
    .req0_data        (req0_data),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_addr        (req1_addr),
    .req1_data        (req1_data),
    .req1_ready       (req1_ready),
    .fb_write_address (fb_write_address),
    .fb_data_in       (fb_data_in),
    .fb_load          (fb_load),
    .oob_flag         (oob_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Monitor: every write seen on the port must match the queue head.
  always @(negedge clk) begin
    if (reset_n && fb_load) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got %0h/%0h, expected none",
                 fb_write_address, fb_data_in);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({fb_write_address, fb_data_in} != e) begin
          errors++;
          $display("FAIL wr_data: got %0h/%0h, expected %0h/%0h",
                   fb_write_address, fb_data_in, e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    int busy, viol, waited;
    logic exp0 [4];
    exp0[0] = 1'b1; exp0[1] = 1'b0; exp0[2] = 1'b1; exp0[3] = 1'b0;

    reset_n = 1'b0;
    clear_req = 1'b0;
    clear_pattern = 16'h0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0;
    req0_data = '0; req1_data = '0;
    tick();
    #1;
    chk("rst_load", fb_load, 0);
    chk("rst_addr", fb_write_address, 0);
    chk("rst_data", fb_data_in, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_oob", oob_flag, 0);
    reset_n = 1'b1;
    tick();

    // Single requester write.
    req0_valid = 1'b1; req0_addr = 16'd5; req0_data = 16'hA5A5;
    #1;
    chk("single_rdy0", req0_ready, 1);
    chk("single_rdy1", req1_ready, 0);
    exp_q.push_back({16'd5, 16'hA5A5});
    tick();
    req0_valid = 1'b0;
    #1;
    chk("single_load", fb_load, 1);
    tick();
    #1;
    chk("idle_load", fb_load, 0);

    // Round robin from reset: 0,1,0,1 with back-to-back writes.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_addr = 16'(20 + i); req0_data = 16'(16'h1000 + i);
      req1_addr = 16'(40 + i); req1_data = 16'(16'h2000 + i);
      #1;
      chk("rr_rdy0", req0_ready, exp0[i]);
      chk("rr_rdy1", req1_ready, !exp0[i]);
      if (exp0[i]) exp_q.push_back({16'(20 + i), 16'(16'h1000 + i)});
      else         exp_q.push_back({16'(40 + i), 16'(16'h2000 + i)});
      tick();
      #1;
      chk("rr_load", fb_load, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rr_drained", exp_q.size(), 0);

    // Out-of-range address: consumed, no write, sticky flag.
    req0_valid = 1'b1; req0_addr = 16'd24000; req0_data = 16'hDEAD;
    #1;
    chk("oob_rdy", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("oob_noload", fb_load, 0);
    chk("oob_flag", oob_flag, 1);
    tick();
    tick();
    #1;
    chk("oob_sticky", oob_flag, 1);

    // Fill with a pending req1; a second clear_req mid-fill is ignored.
    clear_req = 1'b1; clear_pattern = 16'hFFFF;
    req1_valid = 1'b1; req1_addr = 16'd77; req1_data = 16'h1234;
    #1;
    chk("clr_rdy1", req1_ready, 0);
    for (int i = 0; i < N; i++) exp_q.push_back({16'(i), 16'hFFFF});
    tick();
    clear_req = 1'b0; clear_pattern = 16'h0000;
    busy = 0; viol = 0; waited = 0;
    while (waited < 30000) begin
      #1;
      if (req1_ready) break;
      if (clear_busy) busy++;
      if (clear_busy && (req0_ready || req1_ready)) viol++;
      clear_req = (waited == 100);
      tick();
      waited++;
    end
    clear_req = 1'b0;
    chk("clr_busy_cycles", busy, N);
    chk("clr_rdy_viol", viol, 0);
    chk("clr_grant_cycle", waited, N);
    chk("clr_post_rdy1", req1_ready, 1);
    chk("clr_post_busy", clear_busy, 0);
    exp_q.push_back({16'd77, 16'h1234});
    tick();
    req1_valid = 1'b0;
    tick();
    chk("clr_drained", exp_q.size(), 0);
    chk("oob_still", oob_flag, 1);

    // Reset in the middle of a fill.
    clear_req = 1'b1; clear_pattern = 16'h1234;
    for (int i = 0; i <= 1000; i++) exp_q.push_back({16'(i), 16'h1234});
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    #1;
    chk("mid_addr", fb_write_address, 1000);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mr_load", fb_load, 0);
    chk("mr_addr", fb_write_address, 0);
    chk("mr_data", fb_data_in, 0);
    chk("mr_busy", clear_busy, 0);
    chk("mr_oob", oob_flag, 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    #1;
    chk("mr_post_busy", clear_busy, 0);
    chk("mr_post_load", fb_load, 0);
    chk("mr_drained", exp_q.size(), 0);
    req1_valid = 1'b1; req1_addr = 16'd9; req1_data = 16'hBEEF;
    #1;
    chk("mr_arb_rdy1", req1_ready, 1);
    exp_q.push_back({16'd9, 16'hBEEF});
    tick();
    req1_valid = 1'b0;
    tick();
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
